// File: rtl/dmem_store_buffer_if.sv
// Request/response channel between the MEM stage (master) and the store buffer (slave).
interface dmem_store_buffer_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store buffer in front of the data memory bank: queues stores, drains one per cycle, serves loads.
// Define SB_LOAD_FWD_EN to forward queued store data to matching loads.
module dmem_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_store_buffer_if.slave   req_if,
    input  logic                 mem_busy,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic [CW-1:0]        sb_count,
    output logic                 sb_empty
);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;

    logic          full, empty, hit, load_rdy;
    logic          accept, push, load_acc, miss, pop;
    logic [DW-1:0] fwd_data;

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);

    // Youngest match wins: scan oldest to youngest and let later hits overwrite.
`ifdef SB_LOAD_FWD_EN
    logic [PW-1:0] idx;
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == req_if.req_addr)) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
    assign load_rdy = !full && (hit || !mem_busy);
`else
    assign hit      = 1'b0;
    assign fwd_data = '0;
    // Without forwarding a load may only see memory once every older store has landed.
    assign load_rdy = empty && !mem_busy;
`endif

    always_comb begin
        req_if.req_ready = req_if.req_we ? !full : load_rdy;
        accept           = req_if.req_valid && req_if.req_ready;
        push             = accept && req_if.req_we;
        load_acc         = accept && !req_if.req_we;
        miss             = load_acc && !hit;
        pop              = !empty && !mem_busy && !miss;
    end

    // Port mux; forced low while in reset so an in-flight write is cut off at once.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (miss) begin
                mem_read = 1'b1;
                mem_addr = req_if.req_addr;
            end else if (pop) begin
                mem_write = 1'b1;
                mem_addr  = addr_q[head_q];
                mem_wdata = data_q[head_q];
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push) begin
            addr_d[tail_q] = req_if.req_addr;
            data_d[tail_q] = req_if.req_wdata;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        resp_valid_d = load_acc;
        resp_rdata_d = resp_rdata_q;
        if (load_acc) begin
            resp_rdata_d = hit ? fwd_data : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            addr_q       <= addr_d;
            data_q       <= data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_rdata = resp_rdata_q;
    assign sb_count          = count_q;
    assign sb_empty          = empty;
endmodule
